fir_dac_spi: RTL
================

# fir_dac_spi

Output stage downstream of the FIR filter. It accepts each 29-bit signed filter result on a one-cycle strobe and rounds, scales and saturates it to a 12-bit DAC code in offset binary. It then ships the code to an external serial DAC as a 16-bit SPI mode-0 frame, with a one-deep holding register so that a sample arriving mid-frame is not lost.

## Interface
Parameters:
- IN_W, 29, input sample width (signed two's complement)
- OUT_W, 12, DAC code width
- SHIFT, 15, arithmetic right shift applied after rounding; must satisfy 1 ≤ SHIFT < IN_W
- CLK_DIV, 4, CLOCK cycles per SCLK half-period; minimum 2
- CTRL, 4'b0011, control nibble sent ahead of the code

Ports:
- CLOCK  in  1  system clock; the only clock
- RESET  in  1  synchronous, active-high reset
- din  in  IN_W  FIR output sample, signed
- din_valid  in  1  one-CLOCK strobe; din is valid in that cycle
- busy  out  1  high while a frame or its trailing CS-high gap is in progress
- overflow  out  1  one-cycle pulse when the sample being loaded was saturated
- dropped  out  1  one-cycle pulse when an unsent pending sample is overwritten
- dac_cs_n  out  1  SPI chip select, active low
- dac_sclk  out  1  SPI clock; idles low
- dac_mosi  out  1  SPI data, MSB first

## Operation
Quantisation, combinational, applied at load:
- sum = din + 2^(SHIFT-1), computed in IN_W+1 bits so it cannot overflow.
- q = sum >>> SHIFT (arithmetic shift). Rounding is half toward +inf.
- Saturate q to [-2048, 2047]. overflow pulses if clipping occurred.
- Form the code by inverting the MSB of the saturated value (offset binary).
- frame = {CTRL, code}, 16 bits.

FSM states:
- IDLE: dac_cs_n=1, dac_sclk=0, busy=0.
  - A sample is available if din_valid=1 or the pending flag is set; din_valid takes priority over pending.
  - When a sample is available: load the frame, set dac_cs_n=0, drive dac_mosi=frame[15], set busy=1, go to SHIFT.
  - If din_valid and pending are both set, the pending sample is discarded and dropped pulses.
- SHIFT: a half-period counter counts 0..CLK_DIV-1.
  - At each half-period boundary, dac_sclk toggles.
  - On each falling edge after the first rising edge, the shift register advances and dac_mosi presents the next bit.
  - After the 16th rising edge plus one half-period: dac_sclk=0, dac_cs_n=1, go to GAP.
- GAP: hold dac_cs_n=1 for CLK_DIV cycles, then go to IDLE.

Pending register:
- din_valid while busy=1 stores din and sets pending.
- If pending was already set, the new sample overwrites it and dropped pulses.

Reset, from any state and including mid-frame:
- Next edge: state=IDLE, dac_cs_n=1, dac_sclk=0, dac_mosi=0, busy=0, overflow=0, dropped=0.
- The pending flag and the shift register are cleared.

## Timing
- Load latency: din_valid in cycle t produces dac_cs_n=0 and a valid dac_mosi after the edge ending cycle t.
- Bit period is 2·CLK_DIV cycles. Data is stable at every rising SCLK edge, and MOSI changes only while SCLK is low.
- busy is high for exactly 33·CLK_DIV cycles per frame (132 cycles at default).
- Pending sample restart: a pending sample starts in the first IDLE cycle, one cycle after GAP ends.
- Minimum sample spacing without drops is 33·CLK_DIV+1 cycles. The 2 kHz FIR rate is far slower than this.
- din_valid in the last GAP cycle is stored as pending, not dropped.
- overflow and dropped are registered and aligned to the load or overwrite edge.

## Structure
- Shared package `fir_dac_pkg`:
  - FSM state encoding: IDLE, SHIFT, GAP.
  - Default CTRL nibble.
  - Constants SAT_MAX = 2047 and SAT_MIN = -2048.
- Sub-module `fir_out_quant`, purely combinational: round, shift, saturate, offset-binary conversion. It outputs code[OUT_W-1:0] and sat.
- The top level contains the FSM, counters, shift register and pending register.

## Test plan
- RESET then din=0, din_valid pulse → one frame 0x3800 (CTRL 0011, code 0x800); busy high for 132 cycles; overflow=0.
- din=32768000 (1000·2^15) → frame 0x3BE8. din=180224 (5.5·2^15) → frame 0x3806, rounded up.
- din=-114688 (-3.5·2^15) → frame 0x37FD. din=268435455 → frame 0x3FFF with an overflow pulse. din=-268435456 → frame 0x3000 with an overflow pulse.
- Pulse din_valid with A=0, then B=1000·2^15 at cycle 10, then C=-1·2^15 at cycle 20:
  - dropped pulses at cycle 20.
  - Frame 0x3800 is sent first.
  - 0x37FF starts one cycle after the first GAP ends; B is never transmitted.
- Assert RESET at cycle 50 of a frame → next edge: dac_cs_n=1, dac_sclk=0, busy=0. A later din_valid produces a clean full frame.
- SPI checker on every frame:
  - No SCLK edges while dac_cs_n=1.
  - Exactly 16 rising edges per frame.
  - MOSI is stable for CLK_DIV cycles around each rising edge.
  - CS is high for ≥ CLK_DIV cycles between frames.

Source files
------------

// File: rtl/fir_dac_pkg.sv
// Shared definitions for the FIR-to-DAC output stage.
//   - FSM state encoding for the SPI frame sequencer (IDLE, SHIFT, GAP)
//   - default control nibble placed ahead of the 12-bit DAC code
//   - saturation limits of the signed 12-bit intermediate value
package fir_dac_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  localparam logic [3:0] CTRL_DEFAULT = 4'b0011;

  localparam int SAT_MAX = 2047;
  localparam int SAT_MIN = -2048;

endpackage

// File: rtl/fir_out_quant.sv
// Combinational quantiser: rounds a signed filter result half toward +inf,
// arithmetic-shifts it right by SHIFT, saturates to the signed DAC range and
// converts to offset binary.
// Ports:
//   i_din  in  IN_W   signed filter sample
//   code   out OUT_W  offset-binary DAC code
//   sat    out 1      high when the shifted value had to be clipped
module fir_out_quant
  import fir_dac_pkg::*;
#(
  parameter int IN_W  = 29,
  parameter int OUT_W = 12,
  parameter int SHIFT = 15
) (
  input  logic signed [IN_W-1:0]  i_din,
  output logic        [OUT_W-1:0] code,
  output logic                    sat
);

  // One extra bit so adding the rounding constant can never wrap.
  localparam int SUM_W = IN_W + 1;
  localparam logic signed [SUM_W-1:0] RND   = SUM_W'(1) << (SHIFT - 1);
  localparam logic signed [SUM_W-1:0] Q_MAX = SUM_W'(SAT_MAX);
  localparam logic signed [SUM_W-1:0] Q_MIN = SUM_W'(SAT_MIN);

  logic signed [SUM_W-1:0] w_sum;
  logic signed [SUM_W-1:0] w_q;
  logic        [OUT_W-1:0] w_clip;

  // Returns {clipped, value}.
  function automatic logic [OUT_W:0] saturate(input logic signed [SUM_W-1:0] q);
    if (q > Q_MAX) begin
      return {1'b1, OUT_W'(SAT_MAX)};
    end
    if (q < Q_MIN) begin
      return {1'b1, OUT_W'(SAT_MIN)};
    end
    return {1'b0, q[OUT_W-1:0]};
  endfunction

  always_comb begin
    w_sum         = $signed({i_din[IN_W-1], i_din}) + RND;
    w_q           = w_sum >>> SHIFT;
    {sat, w_clip} = saturate(w_q);
    // Offset binary: flipping the sign bit adds 2^(OUT_W-1).
    code          = {~w_clip[OUT_W-1], w_clip[OUT_W-2:0]};
  end

endmodule

// File: rtl/fir_dac_spi.sv
// FIR output stage: quantises each filter sample to a 12-bit offset-binary
// code and ships {CTRL, code} as a 16-bit SPI mode-0 frame, MSB first. A
// one-deep pending register holds a sample that arrives while a frame (or
// the CS-high gap after it) is in progress.
// Ports:
//   CLOCK      in  1     system clock
//   RESET      in  1     synchronous active-high reset
//   din        in  IN_W  signed filter sample
//   din_valid  in  1     one-cycle strobe qualifying din
//   busy       out 1     frame or trailing gap in progress
//   overflow   out 1     pulse: loaded sample was saturated
//   dropped    out 1     pulse: unsent pending sample was overwritten
//   dac_cs_n   out 1     SPI chip select, active low
//   dac_sclk   out 1     SPI clock, idles low
//   dac_mosi   out 1     SPI data
module fir_dac_spi
  import fir_dac_pkg::*;
#(
  parameter int         IN_W    = 29,
  parameter int         OUT_W   = 12,
  parameter int         SHIFT   = 15,
  parameter int         CLK_DIV = 4,
  parameter logic [3:0] CTRL    = CTRL_DEFAULT
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic signed [IN_W-1:0] din,
  input  logic                   din_valid,
  output logic                   busy,
  output logic                   overflow,
  output logic                   dropped,
  output logic                   dac_cs_n,
  output logic                   dac_sclk,
  output logic                   dac_mosi
);

  localparam int FRAME_W = 4 + OUT_W;
  localparam int CNT_W   = $clog2(CLK_DIV);
  localparam int HALF_W  = $clog2(2 * FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * FRAME_W - 1);

  logic [1:0]              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [HALF_W-1:0]       r_half;
  logic [FRAME_W-1:0]      r_shreg;
  logic                    r_pend;
  logic signed [IN_W-1:0]  r_pend_din;
  logic                    r_busy;
  logic                    r_overflow;
  logic                    r_dropped;
  logic                    r_cs_n;
  logic                    r_sclk;
  logic                    r_mosi;

  logic                    w_avail;
  logic signed [IN_W-1:0]  w_qin;
  logic [OUT_W-1:0]        w_code;
  logic                    w_sat;
  logic [FRAME_W-1:0]      w_frame;

  // A fresh strobe always wins over the held sample.
  assign w_avail = din_valid | r_pend;
  assign w_qin   = din_valid ? din : r_pend_din;
  assign w_frame = {CTRL, w_code};

  fir_out_quant #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_quant (
    .i_din (w_qin),
    .code  (w_code),
    .sat   (w_sat)
  );

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_half     <= '0;
      r_shreg    <= '0;
      r_pend     <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_dropped  <= 1'b0;
      r_cs_n     <= 1'b1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      r_dropped  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_avail) begin
            r_shreg    <= w_frame;
            r_mosi     <= w_frame[FRAME_W-1];
            r_cs_n     <= 1'b0;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_half     <= '0;
            r_overflow <= w_sat;
            r_dropped  <= din_valid & r_pend;
            r_pend     <= 1'b0;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_half <= r_half + 1'b1;
            if (r_half == HALF_LAST) begin
              // Final falling edge: close the frame without shifting.
              r_sclk  <= 1'b0;
              r_cs_n  <= 1'b1;
              r_state <= ST_GAP;
            end else begin
              r_sclk <= ~r_sclk;
              // Falling edge: present the next bit while SCLK is low.
              if (r_sclk) begin
                r_shreg <= r_shreg << 1;
                r_mosi  <= r_shreg[FRAME_W-2];
              end
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase

      // Any strobe outside IDLE lands in the pending slot, including the
      // last GAP cycle; it then starts in the following IDLE cycle.
      if (r_state != ST_IDLE && din_valid) begin
        r_pend    <= 1'b1;
        r_dropped <= r_pend;
      end
    end
  end

  // Sample payload needs no reset; r_pend qualifies it.
  always_ff @(posedge CLOCK) begin
    if (r_state != ST_IDLE && din_valid) begin
      r_pend_din <= din;
    end
  end

  assign busy     = r_busy;
  assign overflow = r_overflow;
  assign dropped  = r_dropped;
  assign dac_cs_n = r_cs_n;
  assign dac_sclk = r_sclk;
  assign dac_mosi = r_mosi;

endmodule
